// File: rtl/vga_char_render_if.sv
// Fetch bus between the character renderer and its text-buffer / font memories.
// The renderer drives both addresses; the memories answer one clock later.
interface vga_char_render_if #(
  parameter int TEXT_AW = 12,
  parameter int FONT_AW = 11
);
  logic [TEXT_AW-1:0] text_addr_o;
  logic [6:0]         char_i;
  logic [FONT_AW-1:0] font_addr_o;
  logic [0:7]         font_row_i;

  modport master (
    output text_addr_o,
    output font_addr_o,
    input  char_i,
    input  font_row_i
  );

  modport slave (
    input  text_addr_o,
    input  font_addr_o,
    output char_i,
    output font_row_i
  );
endinterface

// File: rtl/vga_char_render.sv
// Text-mode pixel pipeline: pixel coordinate -> text cell -> glyph row -> RGB,
// with a blinking underline cursor and sync/enable delayed to match (4 clocks).
module vga_char_render #(
  parameter int H_CHARS = 80,
  parameter int V_CHARS = 30,
  parameter int TEXT_AW = 12,
  parameter int FONT_AW = 11
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [9:0]         x_i,
  input  logic [9:0]         y_i,
  input  logic               de_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  vga_char_render_if.master  mem,
  input  logic [11:0]        fg_i,
  input  logic [11:0]        bg_i,
  input  logic               cursor_en_i,
  input  logic [TEXT_AW-1:0] cursor_addr_i,
  output logic [11:0]        rgb_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o
);

  localparam int CELLS = H_CHARS * V_CHARS;

  logic [TEXT_AW-1:0] cell_next;
  logic               hit_next;
  logic               cursor_on_screen;

  logic [TEXT_AW-1:0] text_addr_reg;
  logic [2:0]         xbit_s1_reg, xbit_s2_reg, xbit_s3_reg;
  logic [3:0]         yline_s1_reg, yline_s2_reg;
  logic               de_s1_reg, de_s2_reg, de_s3_reg;
  logic               hs_s1_reg, hs_s2_reg, hs_s3_reg;
  logic               vs_s1_reg, vs_s2_reg, vs_s3_reg;
  logic               hit_s1_reg, hit_s2_reg, hit_s3_reg;

  logic               vsync_prev_reg;
  logic [4:0]         frame_cnt_reg;

  logic               pix;
  logic               blink_on;
  logic [11:0]        colour_next;
  logic [11:0]        rgb_reg;
  logic               hsync_reg, vsync_reg, de_reg;

  assign cell_next = TEXT_AW'(({26'd0, y_i[9:4]} * 32'(H_CHARS)) + {25'd0, x_i[9:3]});

  // A cursor parked beyond the last visible cell can only alias blanked
  // coordinates, so it is simply never shown.
  assign cursor_on_screen = (32'(cursor_addr_i) < CELLS);
  assign hit_next = cursor_en_i && cursor_on_screen &&
                    (cell_next == cursor_addr_i) && (y_i[3:0] >= 4'd14);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      text_addr_reg <= '0;
      xbit_s1_reg   <= '0;
      yline_s1_reg  <= '0;
      de_s1_reg     <= 1'b0;
      hs_s1_reg     <= 1'b1;
      vs_s1_reg     <= 1'b1;
      hit_s1_reg    <= 1'b0;
      xbit_s2_reg   <= '0;
      yline_s2_reg  <= '0;
      de_s2_reg     <= 1'b0;
      hs_s2_reg     <= 1'b1;
      vs_s2_reg     <= 1'b1;
      hit_s2_reg    <= 1'b0;
      xbit_s3_reg   <= '0;
      de_s3_reg     <= 1'b0;
      hs_s3_reg     <= 1'b1;
      vs_s3_reg     <= 1'b1;
      hit_s3_reg    <= 1'b0;
    end else begin
      text_addr_reg <= cell_next;
      xbit_s1_reg   <= x_i[2:0];
      yline_s1_reg  <= y_i[3:0];
      de_s1_reg     <= de_i;
      hs_s1_reg     <= hsync_i;
      vs_s1_reg     <= vsync_i;
      hit_s1_reg    <= hit_next;
      xbit_s2_reg   <= xbit_s1_reg;
      yline_s2_reg  <= yline_s1_reg;
      de_s2_reg     <= de_s1_reg;
      hs_s2_reg     <= hs_s1_reg;
      vs_s2_reg     <= vs_s1_reg;
      hit_s2_reg    <= hit_s1_reg;
      xbit_s3_reg   <= xbit_s2_reg;
      de_s3_reg     <= de_s2_reg;
      hs_s3_reg     <= hs_s2_reg;
      vs_s3_reg     <= vs_s2_reg;
      hit_s3_reg    <= hit_s2_reg;
    end
  end

  assign mem.text_addr_o = text_addr_reg;
  assign mem.font_addr_o = FONT_AW'({mem.char_i, yline_s2_reg});

  // Edge detector starts high so a vsync already low at reset release counts once.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vsync_prev_reg <= 1'b1;
      frame_cnt_reg  <= '0;
    end else begin
      vsync_prev_reg <= vsync_i;
      if (vsync_prev_reg && !vsync_i) begin
        frame_cnt_reg <= frame_cnt_reg + 5'd1;
      end
    end
  end

  assign blink_on = ~frame_cnt_reg[4];
  assign pix      = mem.font_row_i[xbit_s3_reg];

  always_comb begin
    colour_next = pix ? fg_i : bg_i;
    if (hit_s3_reg && blink_on) begin
      colour_next = fg_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rgb_reg   <= '0;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      de_reg    <= 1'b0;
    end else begin
      rgb_reg   <= de_s3_reg ? colour_next : 12'h000;
      hsync_reg <= hs_s3_reg;
      vsync_reg <= vs_s3_reg;
      de_reg    <= de_s3_reg;
    end
  end

  assign rgb_o   = rgb_reg;
  assign hsync_o = hsync_reg;
  assign vsync_o = vsync_reg;
  assign de_o    = de_reg;

endmodule
